fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, a single-entry hold
// register toward decode, and branch redirect with stale-response discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [10:0] ctrl_bits
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] target_pc;

    // Branch targets are forced word aligned.
    assign target_pc = redirect_pc & ~XLEN'(3);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks every other event.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_d = imem_ack ? FETCH : DISCARD;
                end else if (imem_ack) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect || (valid_q && instr_ready)) begin
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; imem_req is decoded from the next state so it
    // leaves a flop with no input-to-output path.
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        imem_req_d = (state_d == FETCH) || (state_d == DISCARD);
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d       = target_pc;
                    req_addr_d = target_pc;
                end else begin
                    req_addr_d = pc_q;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_d = target_pc;
                    if (imem_ack) begin
                        req_addr_d = target_pc;
                    end
                end else if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = req_addr_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_d    = 1'b0;
                    pc_d       = target_pc;
                    req_addr_d = target_pc;
                end else if (valid_q && instr_ready) begin
                    valid_d    = 1'b0;
                    req_addr_d = pc_q;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem_ack) begin
                    req_addr_d = redirect ? target_pc : pc_q;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= RESET_PC;
            valid_q    <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = req_addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign ctrl_bits   = {instr_q[31], instr_q[14:12], instr_q[6:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle vector table plus hand-written
// async-reset and address-wrap sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [10:0] ctrl_bits;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [31:0] w_pc_out;
    logic [10:0] w_ctrl;

    int total;
    int bad;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc_out(pc_out), .ctrl_bits(ctrl_bits)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .instr(w_instr), .pc_out(w_pc_out), .ctrl_bits(w_ctrl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc_out;
        logic [10:0] e_ctrl;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];

    localparam logic [31:0] I_NOP = 32'h0000_0013;
    localparam logic [31:0] I_A   = 32'h8000_7033;
    localparam logic [31:0] I_B   = 32'h0000_2003;
    localparam logic [31:0] I_C   = 32'h00A0_0093;
    localparam logic [31:0] I_D   = 32'h4000_5013;
    localparam logic [31:0] I_E   = 32'h0020_8663;
    localparam logic [31:0] I_F   = 32'h0040_0067;
    localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc,
                                input logic ack, input logic [31:0] rdata,
                                input logic rdy, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc_out,
                                input logic [10:0] e_ctrl);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc_out = e_pc_out; v.e_ctrl = e_ctrl;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%08h want=%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        w_ack = 1'b0; w_rdata = '0; w_redirect = 1'b0; w_redirect_pc = '0; w_ready = 1'b0;

        vecs[0]  = mk(0, 32'h0,   0, 32'h0, 0,  1, 32'h0,   0, I_NOP, 32'h0,   11'h013);
        vecs[1]  = mk(0, 32'h0,   1, I_A,   0,  0, 32'h0,   1, I_A,   32'h0,   11'h7B3);
        vecs[2]  = mk(0, 32'h0,   0, 32'h0, 1,  1, 32'h4,   0, I_A,   32'h0,   11'h7B3);
        vecs[3]  = mk(0, 32'h0,   1, I_B,   0,  0, 32'h4,   1, I_B,   32'h4,   11'h103);
        vecs[4]  = mk(0, 32'h0,   0, 32'h0, 1,  1, 32'h8,   0, I_B,   32'h4,   11'h103);
        vecs[5]  = mk(0, 32'h0,   1, I_C,   0,  0, 32'h8,   1, I_C,   32'h8,   11'h013);
        vecs[6]  = mk(0, 32'h0,   0, 32'h0, 0,  0, 32'h8,   1, I_C,   32'h8,   11'h013);
        vecs[7]  = mk(0, 32'h0,   0, 32'h0, 0,  0, 32'h8,   1, I_C,   32'h8,   11'h013);
        vecs[8]  = mk(0, 32'h0,   1, JUNK,  0,  0, 32'h8,   1, I_C,   32'h8,   11'h013);
        vecs[9]  = mk(0, 32'h0,   0, 32'h0, 0,  0, 32'h8,   1, I_C,   32'h8,   11'h013);
        vecs[10] = mk(0, 32'h0,   0, 32'h0, 0,  0, 32'h8,   1, I_C,   32'h8,   11'h013);
        vecs[11] = mk(0, 32'h0,   0, 32'h0, 1,  1, 32'hC,   0, I_C,   32'h8,   11'h013);
        vecs[12] = mk(0, 32'h0,   1, I_D,   0,  0, 32'hC,   1, I_D,   32'hC,   11'h293);
        vecs[13] = mk(0, 32'h0,   0, 32'h0, 1,  1, 32'h10,  0, I_D,   32'hC,   11'h293);
        vecs[14] = mk(0, 32'h0,   1, I_E,   0,  0, 32'h10,  1, I_E,   32'h10,  11'h063);
        vecs[15] = mk(1, 32'h40,  0, 32'h0, 0,  1, 32'h40,  0, I_E,   32'h10,  11'h063);
        vecs[16] = mk(0, 32'h0,   1, I_F,   0,  0, 32'h40,  1, I_F,   32'h40,  11'h067);
        vecs[17] = mk(0, 32'h0,   0, 32'h0, 1,  1, 32'h44,  0, I_F,   32'h40,  11'h067);
        vecs[18] = mk(0, 32'h0,   0, 32'h0, 0,  1, 32'h44,  0, I_F,   32'h40,  11'h067);
        vecs[19] = mk(1, 32'h103, 0, 32'h0, 0,  1, 32'h44,  0, I_F,   32'h40,  11'h067);
        vecs[20] = mk(0, 32'h0,   0, 32'h0, 0,  1, 32'h44,  0, I_F,   32'h40,  11'h067);
        vecs[21] = mk(0, 32'h0,   0, 32'h0, 0,  1, 32'h44,  0, I_F,   32'h40,  11'h067);
        vecs[22] = mk(0, 32'h0,   1, JUNK,  0,  1, 32'h100, 0, I_F,   32'h40,  11'h067);
        vecs[23] = mk(1, 32'h200, 1, I_NOP, 0,  1, 32'h200, 0, I_F,   32'h40,  11'h067);
        vecs[24] = mk(0, 32'h0,   1, I_A,   0,  0, 32'h200, 1, I_A,   32'h200, 11'h7B3);
        vecs[25] = mk(1, 32'h300, 0, 32'h0, 1,  1, 32'h300, 0, I_A,   32'h200, 11'h7B3);
        vecs[26] = mk(1, 32'h400, 0, 32'h0, 0,  1, 32'h300, 0, I_A,   32'h200, 11'h7B3);
        vecs[27] = mk(1, 32'h500, 1, JUNK,  0,  1, 32'h500, 0, I_A,   32'h200, 11'h7B3);
        vecs[28] = mk(0, 32'h0,   1, I_B,   0,  0, 32'h500, 1, I_B,   32'h500, 11'h103);
        vecs[29] = mk(0, 32'h0,   1, 32'hCAFE_F00D, 1, 1, 32'h504, 0, I_B, 32'h500, 11'h103);
        vecs[30] = mk(0, 32'h0,   1, I_D,   0,  0, 32'h504, 1, I_D,   32'h504, 11'h293);
        vecs[31] = mk(0, 32'h0,   0, 32'h0, 1,  1, 32'h508, 0, I_D,   32'h504, 11'h293);

        // Asynchronous reset state, observed before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_req",    -1, 32'(imem_req),    32'h0);
        check("rst_addr",   -1, imem_addr,        32'h0);
        check("rst_valid",  -1, 32'(instr_valid), 32'h0);
        check("rst_instr",  -1, instr,            I_NOP);
        check("rst_pc_out", -1, pc_out,           32'h0);
        check("rst_w_addr", -1, w_addr,           32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            imem_ack    = vecs[i].ack;
            imem_rdata  = vecs[i].rdata;
            instr_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check("imem_req",    i, 32'(imem_req),    32'(vecs[i].e_req));
            check("imem_addr",   i, imem_addr,        vecs[i].e_addr);
            check("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_valid));
            check("instr",       i, instr,            vecs[i].e_instr);
            check("pc_out",      i, pc_out,           vecs[i].e_pc_out);
            check("ctrl_bits",   i, 32'(ctrl_bits),   32'(vecs[i].e_ctrl));
        end

        // Reset pulse in the middle of an outstanding request, no clock edge.
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req",    100, 32'(imem_req),    32'h0);
        check("mid_rst_valid",  100, 32'(instr_valid), 32'h0);
        check("mid_rst_addr",   100, imem_addr,        32'h0);
        check("mid_rst_instr",  100, instr,            I_NOP);
        check("mid_rst_pc_out", 100, pc_out,           32'h0);

        // Late ack arriving in IDLE must not be taken as a fetch response.
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = JUNK;
        @(posedge clk);
        #1;
        check("post_rst_req",   101, 32'(imem_req),    32'h1);
        check("post_rst_addr",  101, imem_addr,        32'h0);
        check("post_rst_valid", 101, 32'(instr_valid), 32'h0);
        check("wrap_req0",      101, 32'(w_req),       32'h1);
        check("wrap_addr0",     101, w_addr,           32'hFFFF_FFFC);
        @(negedge clk);
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("late_ack_valid", 102, 32'(instr_valid), 32'h0);
        check("late_ack_instr", 102, instr,            I_NOP);
        check("late_ack_addr",  102, imem_addr,        32'h0);

        // Next fetch address wraps from 0xFFFF_FFFC to 0.
        @(negedge clk);
        w_ack = 1'b1; w_rdata = I_E;
        @(posedge clk);
        #1;
        check("wrap_valid",  103, 32'(w_valid), 32'h1);
        check("wrap_pc_out", 103, w_pc_out,     32'hFFFF_FFFC);
        check("wrap_ctrl",   103, 32'(w_ctrl),  32'h063);
        @(negedge clk);
        w_ack = 1'b0; w_ready = 1'b1;
        @(posedge clk);
        #1;
        check("wrap_req1",  104, 32'(w_req),  32'h1);
        check("wrap_addr1", 104, w_addr,      32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
